// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_LO     = 7;
    localparam int MID        = 8;
    localparam int MID_HI     = 9;
    localparam int DATA_BITS  = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through byte FIFO; head is visible the cycle after its push.
// A push while full is dropped (flagged on drop) unless a pop lands in the same cycle.
module sync_fifo #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic        empty,
    output logic        full,
    output logic [AW:0] level,
    output logic        drop
);

    localparam int DEPTH = 2 ** AW;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_pop;
    logic        do_push;

    assign empty   = (wptr == rptr);
    assign full    = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
    assign level   = wptr - rptr;
    assign rdata   = mem[rptr[AW-1:0]];

    // Pop is resolved first, so a full FIFO can still accept a same-cycle push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampling, 3-sample majority) feeding a FWFT byte FIFO.
// Byte reaches the FIFO one cycle after the mid-stop decision; overflowing bytes are dropped.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int FIFO_AW    = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx,
    input  logic                  rd,
    output logic [7:0]            rdata,
    output logic                  empty,
    output logic                  full,
    output logic [FIFO_AW:0]      level,
    output logic                  frame_err,
    output logic                  overrun_err,
    input  logic                  clr_err
);

    localparam logic [3:0] S_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    logic                  rx_s1;
    logic                  rx_s2;
    logic                  rx_d;
    logic                  fall;

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [PRESCALE_W-1:0] tcnt;
    logic                  tick;
    logic [3:0]            s_cnt;
    logic [3:0]            s_nxt;
    logic [2:0]            idx;
    logic [2:0]            idx_nxt;
    logic [7:0]            shreg;
    logic [7:0]            shreg_nxt;
    logic [2:0]            smp;
    logic                  maj_full;
    logic                  maj_stop;

    logic                  push_nxt;
    logic                  push_q;
    logic [7:0]            push_dat;
    logic                  ferr_set;
    logic                  ovr_set;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Edge-qualified start: a line already low when enabled does not open a frame.
    assign fall = rx_d & ~rx_s2;

    assign tick = (state != IDLE) && (tcnt == prescale);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tcnt <= '0;
        end else if (state == IDLE || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            smp <= 3'b000;
        end else if (tick) begin
            if (s_cnt == 4'(MID_LO)) smp[0] <= rx_s2;
            if (s_cnt == 4'(MID))    smp[1] <= rx_s2;
            if (s_cnt == 4'(MID_HI)) smp[2] <= rx_s2;
        end
    end

    assign maj_full = maj3(smp[0], smp[1], smp[2]);
    // Stop bit is resolved on its third sample, before it is registered.
    assign maj_stop = maj3(smp[0], smp[1], rx_s2);

    always_comb begin
        state_nxt = state;
        s_nxt     = s_cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        push_nxt  = 1'b0;
        ferr_set  = 1'b0;

        if (!en) begin
            state_nxt = IDLE;
            s_nxt     = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    s_nxt   = 4'd0;
                    idx_nxt = 3'd0;
                    if (fall) begin
                        state_nxt = START;
                    end
                end
                START: begin
                    if (tick) begin
                        s_nxt = s_cnt + 4'd1;
                        if (s_cnt == S_LAST) begin
                            idx_nxt   = 3'd0;
                            state_nxt = maj_full ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        s_nxt = s_cnt + 4'd1;
                        if (s_cnt == S_LAST) begin
                            shreg_nxt[idx] = maj_full;
                            if (idx == IDX_LAST) begin
                                state_nxt = STOP;
                            end else begin
                                idx_nxt = idx + 3'd1;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        s_nxt = s_cnt + 4'd1;
                        // Leave half a bit early so a back-to-back start edge is caught.
                        if (s_cnt == 4'(MID_HI)) begin
                            state_nxt = IDLE;
                            s_nxt     = 4'd0;
                            push_nxt  = maj_stop;
                            ferr_set  = ~maj_stop;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= IDLE;
            s_cnt    <= 4'd0;
            idx      <= 3'd0;
            shreg    <= 8'h00;
            push_q   <= 1'b0;
            push_dat <= 8'h00;
        end else begin
            state  <= state_nxt;
            s_cnt  <= s_nxt;
            idx    <= idx_nxt;
            shreg  <= shreg_nxt;
            push_q <= push_nxt;
            if (push_nxt) begin
                push_dat <= shreg;
            end
        end
    end

    sync_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push_q),
        .wdata (push_dat),
        .pop   (rd),
        .rdata (rdata),
        .empty (empty),
        .full  (full),
        .level (level),
        .drop  (ovr_set)
    );

    // A same-cycle error event beats the clear.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ovr_set) begin
                overrun_err <= 1'b1;
            end else if (clr_err) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synthesizable UART receiver with 16x oversampling and a first-word-fall-through receive FIFO.
- Consumes the SoC UART TX line (RsTx_Sys0_SS0_S0) as the checking stage downstream of the UART.
- Also serves as the RX front end the UART slaves reuse.
- Frame format: 8N1, LSB first; the default line rate matches the 16-clock bit period on the 10 ns HCLK.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries
PRESCALE_W, 16, width of the prescale input

Ports:
HCLK  input  1  system clock
HRESET  input  1  asynchronous active-high reset
en  input  1  receiver enable; low forces the FSM to IDLE
prescale  input  PRESCALE_W  HCLK cycles per oversample tick, minus 1 (default use: 0 gives 16 clk/bit)
rx  input  1  serial line, idle high, asynchronous to HCLK
rd  input  1  pop strobe; ignored when empty
rdata  output  8  FIFO head byte (FWFT), valid when empty=0
empty  output  1  FIFO empty
full  output  1  FIFO full
level  output  FIFO_AW+1  number of stored bytes, 0..16
frame_err  output  1  sticky: stop bit sampled low
overrun_err  output  1  sticky: byte received while full
clr_err  input  1  clears both sticky error flags

Behaviour:
- Reset values (HRESET high, asynchronous): rdata=0, empty=1, full=0, level=0, frame_err=0, overrun_err=0. Synchronizer flops reset to 1. FSM goes to IDLE. Pointers and the tick counter go to 0.
- rx passes through a 2-flop synchronizer; it is 2 cycles late before any decision.
- Tick generator:
  - Counter runs while state≠IDLE; it reloads to 0 in IDLE.
  - A tick pulses when the counter equals prescale, then the counter wraps to 0.
  - prescale=0 gives a tick every cycle.
- Each bit spans 16 ticks. A sample counter s counts 0..15. Bit value = majority of synchronized rx at s=7, 8, 9.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on synchronized rx (1→0) with en=1 → START, with s=0 and the tick counter cleared.
  - START: at s=15, if the majority is 0 → DATA with bit index 0; if the majority is 1 (glitch) → IDLE, nothing pushed.
  - DATA: at s=15, shift the majority into shreg[idx], LSB first. After idx=7 → STOP.
  - STOP: at s=9 the stop majority is known, and the FSM → IDLE immediately (half-bit early, so back-to-back frames are not missed).
    - Stop=1: push shreg.
    - Stop=0: set frame_err and discard the byte.
- Push/pop rules:
  - A push while full drops the byte and sets overrun_err.
  - When rd and push occur in the same cycle while full, the pop is applied first and the push succeeds; level stays 16.
  - rd and push in the same cycle when empty: the push succeeds and rd is ignored; level becomes 1.
  - rd while empty: no effect.
- FWFT timing:
  - rdata reflects mem[rptr] combinationally from registered state.
  - A pushed byte is visible on rdata the cycle after the push cycle; empty deasserts at the same time.
- Pointers are FIFO_AW+1 bits and wrap naturally.
  - full = (wptr^rptr) == {1'b1, 0...}.
  - level = wptr - rptr.
- clr_err clears both flags. If an error event occurs in the same cycle as clr_err, the flag is set (the set wins).
- en deasserted mid-frame: FSM → IDLE at the next edge, the partial byte is discarded, and the FIFO is untouched. Re-enabling while rx is low does not start a frame until the next falling edge.
- HRESET mid-frame: everything returns to reset values, and FIFO contents are lost.
- Latency: the byte is in the FIFO 2 (sync) + 16·(1+8)+10 ticks after the start edge, plus 1 cycle for the push register.

Decomposition:
- Package uart_rx_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - constants OVERSAMPLE=16, MID_LO=7, MID=8, MID_HI=9, DATA_BITS=8.
- One sub-module, sync_fifo (parameter AW, width 8, FWFT, pop-before-push ordering), instantiated once. The receiver FSM, tick generator and synchronizer stay in the top.

Test Plan:
- Reset then frame 0x41 at prescale=0 (160 ns/bit) → rdata=0x41, empty=0, level=1 after 2+154 ticks +1 cycle; rd → empty=1, level=0.
- Back-to-back frames "Hi\n" (0x48, 0x69, 0x0A) with no idle gap, prescale=0 → three pushes in order, no frame_err.
- 17 frames with no reads → level=16 and full=1 after 16; the 17th sets overrun_err=1 and rdata stays at byte 0. Then rd coincident with an 18th push → level remains 16 and the 18th byte is stored.
- Frame 0x55 with stop bit driven low → frame_err=1, level unchanged. clr_err pulse → frame_err=0. clr_err in the same cycle as a new framing error → frame_err=1.
- 4-clock low glitch on rx while idle → START aborts to IDLE, level=0, no errors.
- Reset asserted mid-DATA of 0xA5 after 3 bits, and separately en dropped mid-frame → no push; after release a clean 0x3C frame is received correctly. prescale=9 (1600 ns/bit) variant repeats the 0x41 check.
